// File: rtl/rnn_pkg.sv
// ----------------------------------------------------------------------------
// rnn_pkg : shared types, register map and fixed-point helpers for rnn_seq_engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rnn_pkg;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ACC_INIT   = 4'd1,
      S_MAC_X      = 4'd2,
      S_MAC_H      = 4'd3,
      S_ACT        = 4'd4,
      S_DENSE_INIT = 4'd5,
      S_DENSE_MAC  = 4'd6,
      S_DONE       = 4'd7
   } state_t;

   localparam logic [3:0] ADDR_CTRL    = 4'd0;
   localparam logic [3:0] ADDR_X       = 4'd1;
   localparam logic [3:0] ADDR_WIH     = 4'd2;
   localparam logic [3:0] ADDR_WHH     = 4'd3;
   localparam logic [3:0] ADDR_B       = 4'd4;
   localparam logic [3:0] ADDR_D       = 4'd5;
   localparam logic [3:0] ADDR_DBIAS   = 4'd6;
   localparam logic [3:0] ADDR_RESULT  = 4'd7;
   localparam logic [3:0] ADDR_SEQ_LEN = 4'd8;

   // Operands arrive sign-extended to 32 bits; the product is formed at 64 bits.
   function automatic logic signed [63:0] fx_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int frac);
      logic signed [63:0] ae;
      logic signed [63:0] be;
      ae = 64'(a);
      be = 64'(b);
      return (ae * be) >>> frac;
   endfunction

   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                 input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rnn_mac.sv
// ----------------------------------------------------------------------------
// rnn_mac : registered signed multiply-shift-accumulate with saturated views
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rnn_mac
   import rnn_pkg::*;
#(
   parameter int DW        = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          en,
   input  logic [DW-1:0] init_val,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sat_q,
   output logic [DW-1:0] sat_d
);

   logic signed [DW-1:0]    a_s;
   logic signed [DW-1:0]    b_s;
   logic signed [DW-1:0]    iv_s;
   logic signed [31:0]      a_x;
   logic signed [31:0]      b_x;
   logic signed [ACC_W-1:0] iv_x;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [63:0]      acc_q64;
   logic signed [63:0]      acc_d64;

   assign a_s  = a;
   assign b_s  = b;
   assign iv_s = init_val;
   assign a_x  = 32'(a_s);
   assign b_x  = 32'(b_s);
   assign iv_x = ACC_W'(iv_s);

   // The accumulator wraps; saturation is only applied to the observed views.
   always_comb begin
      acc_d = acc_q;
      if (init)
         acc_d = iv_x;
      else if (en)
         acc_d = acc_q + ACC_W'(fx_mul(a_x, b_x, FRAC_BITS));
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc_q64 = 64'(acc_q);
   assign acc_d64 = 64'(acc_d);
   assign sat_q   = DW'(sat_dw(acc_q64, DW));
   assign sat_d   = DW'(sat_dw(acc_d64, DW));

endmodule

`default_nettype wire

// File: rtl/rnn_tanh.sv
// ----------------------------------------------------------------------------
// rnn_tanh : single-cycle piecewise-linear tanh (slope 1, then 1/2, then flat)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rnn_tanh #(
   parameter int DW        = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic [DW-1:0] x,
   output logic [DW-1:0] y
);

   localparam int W = DW + 1;
   localparam logic [W-1:0] ONE      = W'(1) << FRAC_BITS;
   localparam logic [W-1:0] HALF     = ONE >> 1;
   localparam logic [W-1:0] QUARTER  = ONE >> 2;
   localparam logic [W-1:0] ONE_HALF = ONE + HALF;

   logic [W-1:0] xe;
   logic [W-1:0] ax;
   logic [W-1:0] ya;

   assign xe = {x[DW-1], x};
   assign ax = x[DW-1] ? (~xe + W'(1)) : xe;

   always_comb begin
      ya = ONE;
      if (ax <= HALF)
         ya = ax;
      else if (ax <= ONE_HALF)
         ya = QUARTER + (ax >> 1);
      y = DW'(x[DW-1] ? (~ya + W'(1)) : ya);
   end

endmodule

`default_nettype wire

// File: rtl/rnn_seq_engine.sv
// ----------------------------------------------------------------------------
// rnn_seq_engine : memory-mapped full-sequence RNN with dense output layer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rnn_seq_engine
   import rnn_pkg::*;
#(
   parameter int EMB_LEN   = 4,
   parameter int HID_LEN   = 32,
   parameter int SEQ_DEPTH = 16,
   parameter int DW        = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        irq
);

   localparam int XW = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
   localparam int EW = (EMB_LEN > 1)   ? $clog2(EMB_LEN)   : 1;
   localparam int HW = (HID_LEN > 1)   ? $clog2(HID_LEN)   : 1;
   localparam logic [8:0]  DEPTH_C  = 9'(SEQ_DEPTH);
   localparam logic [15:0] DEPTH16  = 16'(SEQ_DEPTH);
   localparam logic [8:0]  EMB_C    = 9'(EMB_LEN);
   localparam logic [8:0]  HID_C    = 9'(HID_LEN);
   localparam logic [7:0]  EMB_LAST = 8'(EMB_LEN - 1);
   localparam logic [7:0]  HID_LAST = 8'(HID_LEN - 1);

   logic [DW-1:0] x_mem  [SEQ_DEPTH][EMB_LEN];
   logic [DW-1:0] wih    [EMB_LEN][HID_LEN];
   logic [DW-1:0] whh    [HID_LEN][HID_LEN];
   logic [DW-1:0] b_mem  [HID_LEN];
   logic [DW-1:0] d_mem  [HID_LEN];
   logic [DW-1:0] dense_bias;
   logic [DW-1:0] h_mem  [2][HID_LEN];

   state_t        state, state_nx;
   logic [7:0]    cnt, j;
   logic [8:0]    t, seq_len;
   logic          bank;
   logic [DW-1:0] result;

   logic [7:0]    row, col;
   logic [DW-1:0] val;
   logic          wr_ok, start, clear, busy, valid;
   logic          mac_init, mac_en;
   logic [DW-1:0] init_val, op_a, op_b, sat_q, sat_d, tanh_y;

   assign row   = data_in[31:24];
   assign col   = data_in[23:16];
   assign val   = data_in[DW-1:0];
   assign wr_ok = write && (state == S_IDLE || state == S_DONE);
   assign start = wr_ok && addr == ADDR_CTRL && data_in[0];
   assign clear = wr_ok && addr == ADDR_CTRL && data_in[1];
   assign busy  = !(state == S_IDLE || state == S_DONE);
   assign valid = (state == S_DONE);
   assign irq   = valid;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         case (addr)
            ADDR_X:
               if ({1'b0, row} < DEPTH_C && {1'b0, col} < EMB_C)
                  x_mem[row[XW-1:0]][col[EW-1:0]] <= val;
            ADDR_WIH:
               if ({1'b0, row} < EMB_C && {1'b0, col} < HID_C)
                  wih[row[EW-1:0]][col[HW-1:0]] <= val;
            ADDR_WHH:
               if ({1'b0, row} < HID_C && {1'b0, col} < HID_C)
                  whh[row[HW-1:0]][col[HW-1:0]] <= val;
            ADDR_B:     if ({1'b0, col} < HID_C) b_mem[col[HW-1:0]] <= val;
            ADDR_D:     if ({1'b0, col} < HID_C) d_mem[col[HW-1:0]] <= val;
            ADDR_DBIAS: dense_bias <= val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         seq_len <= '0;
      else if (wr_ok && addr == ADDR_SEQ_LEN)
         seq_len <= (data_in[15:0] > DEPTH16) ? DEPTH_C : data_in[8:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start)
               state_nx = (seq_len == 9'd0) ? S_DENSE_INIT : S_ACC_INIT;
            else if (state == S_DONE && read && addr == ADDR_RESULT)
               state_nx = S_IDLE;
         end
         S_ACC_INIT:   state_nx = S_MAC_X;
         S_MAC_X:      if (cnt == EMB_LAST) state_nx = S_MAC_H;
         S_MAC_H:      if (cnt == HID_LAST) state_nx = S_ACT;
         S_ACT: begin
            if (j != HID_LAST || t + 9'd1 < seq_len) state_nx = S_ACC_INIT;
            else                                     state_nx = S_DENSE_INIT;
         end
         S_DENSE_INIT: state_nx = S_DENSE_MAC;
         S_DENSE_MAC:  if (cnt == HID_LAST) state_nx = S_DONE;
         default:      state_nx = S_IDLE;
      endcase
   end

   // MAC_H and DENSE_MAC read the bank filled last timestep; ACT fills the other.
   always_comb begin
      mac_init = 1'b0;
      mac_en   = 1'b0;
      init_val = '0;
      op_a     = '0;
      op_b     = '0;
      case (state)
         S_ACC_INIT: begin
            mac_init = 1'b1;
            init_val = b_mem[j[HW-1:0]];
         end
         S_MAC_X: begin
            mac_en = 1'b1;
            op_a   = x_mem[t[XW-1:0]][cnt[EW-1:0]];
            op_b   = wih[cnt[EW-1:0]][j[HW-1:0]];
         end
         S_MAC_H: begin
            mac_en = 1'b1;
            op_a   = h_mem[bank][cnt[HW-1:0]];
            op_b   = whh[cnt[HW-1:0]][j[HW-1:0]];
         end
         S_DENSE_INIT: begin
            mac_init = 1'b1;
            init_val = dense_bias;
         end
         S_DENSE_MAC: begin
            mac_en = 1'b1;
            op_a   = h_mem[bank][cnt[HW-1:0]];
            op_b   = d_mem[cnt[HW-1:0]];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         j    <= '0;
         t    <= '0;
         bank <= 1'b0;
      end else begin
         cnt <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
         if (start) begin
            j <= '0;
            t <= '0;
         end else if (state == S_ACT) begin
            if (j == HID_LAST) begin
               j    <= '0;
               t    <= t + 9'd1;
               bank <= ~bank;
            end else begin
               j <= j + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int bk = 0; bk < 2; bk++)
            for (int k = 0; k < HID_LEN; k++)
               h_mem[bk][k] <= '0;
      end else if (state == S_ACT) begin
         h_mem[~bank][j[HW-1:0]] <= tanh_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         result <= '0;
      else if (state == S_DENSE_MAC && state_nx == S_DONE)
         result <= sat_d;
   end

   always_comb begin
      data_out = '0;
      if (read) begin
         case (addr)
            ADDR_CTRL:    data_out = {30'd0, busy, valid};
            ADDR_RESULT:  data_out = {{(32-DW){result[DW-1]}}, result};
            ADDR_SEQ_LEN: data_out = {23'd0, seq_len};
            default:      data_out = '0;
         endcase
      end
   end

   rnn_mac #(
      .DW        (DW),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .init     (mac_init),
      .en       (mac_en),
      .init_val (init_val),
      .a        (op_a),
      .b        (op_b),
      .sat_q    (sat_q),
      .sat_d    (sat_d)
   );

   rnn_tanh #(
      .DW        (DW),
      .FRAC_BITS (FRAC_BITS)
   ) u_tanh (
      .x (sat_q),
      .y (tanh_y)
   );

endmodule

`default_nettype wire

// File: tb/tb_rnn_seq_engine.sv
// ----------------------------------------------------------------------------
// tb_rnn_seq_engine : randomized self-checking bench with a loop-level sequence model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rnn_seq_engine;
   import rnn_pkg::*;

   localparam int E = 4;
   localparam int H = 32;
   localparam int S = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   int mx[S][E];
   int mwih[E][H];
   int mwhh[H][H];
   int mb[H];
   int md[H];
   int mdb;
   int mh[H];
   int mseq;

   always #5 clk = ~clk;

   rnn_seq_engine dut (
      .clk      (clk),
      .rst      (rst),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic int s16(input int v);
      int r;
      r = v & 32'hFFFF;
      if (r >= 32768) r -= 65536;
      return r;
   endfunction

   function automatic longint wrap24(input longint v);
      longint r;
      r = v & 64'hFFFFFF;
      if (r >= (64'sd1 << 23)) r -= (64'sd1 << 24);
      return r;
   endfunction

   function automatic int sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic longint fxm(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return p >>> 8;
   endfunction

   function automatic int tanh_m(input int v);
      int a, r;
      a = (v < 0) ? -v : v;
      if (a <= 128)      r = a;
      else if (a <= 384) r = 64 + a / 2;
      else               r = 256;
      return (v < 0) ? -r : r;
   endfunction

   // Whole-sequence reference: new hidden vector built from the old one, then swapped.
   task automatic model_run(output int res);
      int     hn[H];
      longint acc;
      for (int ts = 0; ts < mseq; ts++) begin
         for (int jj = 0; jj < H; jj++) begin
            acc = mb[jj];
            for (int i = 0; i < E; i++) acc = wrap24(acc + fxm(mx[ts][i], mwih[i][jj]));
            for (int k = 0; k < H; k++) acc = wrap24(acc + fxm(mh[k], mwhh[k][jj]));
            hn[jj] = tanh_m(sat16(acc));
         end
         mh = hn;
      end
      acc = mdb;
      for (int k = 0; k < H; k++) acc = wrap24(acc + fxm(mh[k], md[k]));
      res = sat16(acc);
   endtask

   task automatic wr(input logic [3:0] a, input int row, input int col, input int v);
      @(negedge clk);
      write   = 1'b1;
      addr    = a;
      data_in = {8'(row), 8'(col), 16'(v)};
      @(posedge clk);
      #1 write = 1'b0;
      case (a)
         ADDR_CTRL:    if (v & 2) foreach (mh[k]) mh[k] = 0;
         ADDR_X:       mx[row][col] = s16(v);
         ADDR_WIH:     mwih[row][col] = s16(v);
         ADDR_WHH:     mwhh[row][col] = s16(v);
         ADDR_B:       mb[col] = s16(v);
         ADDR_D:       md[col] = s16(v);
         ADDR_DBIAS:   mdb = s16(v);
         ADDR_SEQ_LEN: mseq = ((v & 32'hFFFF) > S) ? S : (v & 32'hFFFF);
         default: ;
      endcase
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      @(negedge clk);
      read = 1'b1;
      addr = a;
      #1 v = data_out;
      @(posedge clk);
      #1 read = 1'b0;
   endtask

   function automatic int rsmall(input int span);
      return int'($urandom_range(0, 2 * span - 1)) - span;
   endfunction

   task automatic fill(input bit rnd);
      for (int ts = 0; ts < S; ts++)
         for (int i = 0; i < E; i++) wr(ADDR_X, ts, i, rnd ? rsmall(256) : 0);
      for (int i = 0; i < E; i++)
         for (int jj = 0; jj < H; jj++) wr(ADDR_WIH, i, jj, rnd ? rsmall(64) : 0);
      for (int k = 0; k < H; k++)
         for (int jj = 0; jj < H; jj++) wr(ADDR_WHH, k, jj, rnd ? rsmall(64) : 0);
      for (int k = 0; k < H; k++) begin
         wr(ADDR_B, 0, k, rnd ? rsmall(64) : 0);
         wr(ADDR_D, 0, k, rnd ? rsmall(256) : 0);
      end
   endtask

   // Starts a run, waits for irq within a cycle budget and checks the latency.
   task automatic run(input bit do_clear, input bit lockout, output int exp_res);
      int cyc, exp_lat;
      exp_lat = mseq * H * (E + H + 2) + H + 1;
      if (do_clear) foreach (mh[k]) mh[k] = 0;
      model_run(exp_res);
      @(negedge clk);
      write   = 1'b1;
      addr    = ADDR_CTRL;
      data_in = {30'd0, do_clear, 1'b1};
      @(posedge clk);
      #1 write = 1'b0;
      cyc = 0;
      while (!irq && cyc < 20000) begin
         @(negedge clk);
         write = 1'b0;
         if (lockout && cyc == 10) begin
            write = 1'b1; addr = ADDR_WIH; data_in = {8'd0, 8'd1, 16'h7FFF};
         end
         if (lockout && cyc == 12) begin
            write = 1'b1; addr = ADDR_CTRL; data_in = 32'd1;
         end
         @(posedge clk);
         #1 cyc++;
      end
      write = 1'b0;
      check("latency", cyc, exp_lat);
   endtask

   initial begin
      logic [31:0] v;
      int          er;

      foreach (mh[k]) mh[k] = 0;
      mseq = 0;
      mdb  = 0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_data_out", data_out, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_CTRL, v);   check("rst_ctrl", v, 32'd0);
      rd(ADDR_RESULT, v); check("rst_result", v, 32'd0);

      // Dense layer only
      wr(ADDR_CTRL, 0, 0, 2);
      wr(ADDR_DBIAS, 0, 0, 16'h0010);
      wr(ADDR_SEQ_LEN, 0, 0, 0);
      run(1'b0, 1'b0, er);
      check("dense_irq", {31'd0, irq}, 32'd1);
      rd(ADDR_CTRL, v);   check("dense_ctrl_valid", v, 32'd1);
      rd(ADDR_RESULT, v); check("dense_result", v, 32'h0000_0010);
      check("dense_ack_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_CTRL, v);   check("dense_ack_ctrl", v, 32'd0);

      // Zero activations over two timesteps
      fill(1'b0);
      wr(ADDR_D, 0, 0, 16'h0100);
      wr(ADDR_DBIAS, 0, 0, 16'hFFF0);
      wr(ADDR_SEQ_LEN, 0, 0, 2);
      run(1'b1, 1'b0, er);
      rd(ADDR_RESULT, v); check("zero_result", v, 32'hFFFF_FFF0);

      // Positive and negative saturation of the dense output
      for (int i = 0; i < E; i++) begin
         wr(ADDR_X, 0, i, 16'h0400);
         for (int jj = 0; jj < H; jj++) wr(ADDR_WIH, i, jj, 16'h0100);
      end
      for (int k = 0; k < H; k++) wr(ADDR_D, 0, k, 16'h7FFF);
      wr(ADDR_DBIAS, 0, 0, 16'h7F00);
      wr(ADDR_SEQ_LEN, 0, 0, 1);
      run(1'b1, 1'b0, er);
      rd(ADDR_RESULT, v); check("sat_pos", v, 32'h0000_7FFF);
      for (int k = 0; k < H; k++) wr(ADDR_D, 0, k, 16'h8001);
      wr(ADDR_DBIAS, 0, 0, 16'h8100);
      run(1'b1, 1'b0, er);
      rd(ADDR_RESULT, v); check("sat_neg", v, 32'hFFFF_8000);

      // SEQ_LEN clamp
      wr(ADDR_SEQ_LEN, 0, 0, 300);
      rd(ADDR_SEQ_LEN, v); check("seq_clamp", v, 32'(S));

      // Random recurrences; later trials continue the hidden state without clear
      fill(1'b1);
      wr(ADDR_SEQ_LEN, 0, 0, 3);
      for (int tr = 0; tr < 3; tr++) begin
         run(tr == 0, 1'b0, er);
         rd(ADDR_RESULT, v); check("pingpong_result", v, 32'(er));
      end

      // Writes and start during a run are ignored
      wr(ADDR_SEQ_LEN, 0, 0, 1);
      run(1'b1, 1'b1, er);
      rd(ADDR_RESULT, v); check("lockout_result", v, 32'(er));
      run(1'b1, 1'b0, er);
      rd(ADDR_RESULT, v); check("lockout_rerun", v, 32'(er));

      // Reset in the middle of a run
      @(negedge clk);
      write = 1'b1; addr = ADDR_CTRL; data_in = 32'd1;
      @(posedge clk);
      #1 write = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      foreach (mh[k]) mh[k] = 0;
      mseq = 0;
      rd(ADDR_CTRL, v); check("midrst_ctrl", v, 32'd0);
      wr(ADDR_SEQ_LEN, 0, 0, 0);
      run(1'b0, 1'b0, er);
      rd(ADDR_RESULT, v); check("midrst_result", v, 32'(mdb));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
